// File: rtl/fc_frame_loader.sv
// -----------------------------------------------------------------------------
// fc_frame_loader
//
// Sequential front/back end for one fully-connected output neuron group.
//   * Collects IN activations from a valid/ready stream into the parallel
//     vector x_out[0:IN-1] that drives the combinational FC layer.
//   * Freezes x_out for SETTLE_CYC cycles so the multiplier/adder/ReLU tree
//     settles, then registers the layer result z_in into m_data.
//   * Offers the result on a valid/ready output stream.
//   * Flags frames of the wrong length with a one-cycle err_len pulse.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   input beat handshake
//   s_data, s_last    activation value, final beat of a frame
//   x_out[0:IN-1]     parallel activation vector to the layer
//   z_in              layer result (OUT_W bits)
//   m_valid/m_ready   result handshake
//   m_data            registered layer result
//   err_len           one-cycle pulse on frame length error
//   frame_cnt         (FC_PERF_CNT_EN only) completed result handshakes, wraps
//   stall_cnt         (FC_PERF_CNT_EN only) cycles a result waits on m_ready,
//                     saturates
//
// Configuration macro: FC_PERF_CNT_EN adds the frame_cnt/stall_cnt counters.
// SETTLE_CYC legal range is 1..15.
// -----------------------------------------------------------------------------
module fc_frame_loader #(
  parameter int WIDTH      = 8,
  parameter int IN         = 128,
  parameter int OUT_W      = WIDTH * 2 + $clog2(IN),
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x_out [0:IN-1],
  input  logic [OUT_W-1:0] z_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
`ifdef FC_PERF_CNT_EN
  output logic [15:0]      frame_cnt,
  output logic [15:0]      stall_cnt,
`endif
  output logic             err_len
);

  localparam int IDX_W = $clog2(IN);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(IN - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SETTLE,
    ST_OUT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       settle_cnt;

  wire beat_acc = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FILL;
      idx        <= '0;
      settle_cnt <= '0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      err_len    <= 1'b0;
      // NOTE: x_out is a register file that is normally left unreset, but the
      // layer sees it directly, so it must present zeros out of reset.
      for (int i = 0; i < IN; i++) begin
        x_out[i] <= '0;
      end
    end else begin
      // NOTE: every state register here uses <= so all branches see the
      // values from before this edge; err_len defaults low to make it a pulse.
      err_len <= 1'b0;

      unique case (state)
        ST_FILL: begin
          // s_ready is a registered copy of "state is FILL"; it stays low
          // during reset and rises on the first clock after release.
          s_ready <= 1'b1;
          if (beat_acc) begin
            x_out[idx] <= s_data;
            if (idx == IDX_LAST) begin
              // Full frame: process it even when s_last is missing.
              idx        <= '0;
              settle_cnt <= '0;
              s_ready    <= 1'b0;
              err_len    <= !s_last;
              state      <= ST_SETTLE;
            end else if (s_last) begin
              // Short frame: drop it, keep stale entries, restart at index 0.
              idx     <= '0;
              err_len <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            m_data  <= z_in;
            m_valid <= 1'b1;
            state   <= ST_OUT;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        ST_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= ST_FILL;
          end
        end

        default: begin
          state   <= ST_FILL;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else if (state == ST_OUT) begin
      if (m_ready) begin
        frame_cnt <= frame_cnt + 1'b1;          // wraps naturally
      end else if (stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 1'b1;          // saturates
      end
    end
  end
`endif

endmodule

// File: tb/tb_fc_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_fc_frame_loader
//
// Scoreboard bench for fc_frame_loader. A driver issues beats; when a beat is
// accepted, a frame-level model (array of the last value written to each slot,
// beat count within the current frame) decides whether a length error or a
// completed frame results, and pushes the expected result (sum of the frame
// array and the cycle it must appear on) into a queue. A monitor pops and
// compares whenever m_valid rises and also checks handshake/hold behaviour.
// The layer itself is stubbed as z = sum(x_out).
// -----------------------------------------------------------------------------
module tb_fc_frame_loader;

  localparam int WIDTH      = 8;
  localparam int IN         = 128;
  localparam int OUT_W      = WIDTH * 2 + $clog2(IN);
  localparam int SETTLE_CYC = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic [WIDTH-1:0] x_out [0:IN-1];
  logic [OUT_W-1:0] z_in;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [OUT_W-1:0] m_data;
  logic             err_len;
`ifdef FC_PERF_CNT_EN
  logic [15:0]      frame_cnt;
  logic [15:0]      stall_cnt;
`endif

  fc_frame_loader #(
    .WIDTH(WIDTH), .IN(IN), .OUT_W(OUT_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .x_out(x_out), .z_in(z_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef FC_PERF_CNT_EN
    .frame_cnt(frame_cnt), .stall_cnt(stall_cnt),
`endif
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Layer stub: z = sum of the activation vector.
  always_comb begin
    z_in = '0;
    for (int i = 0; i < IN; i++) z_in = z_in + OUT_W'(x_out[i]);
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [OUT_W-1:0] data;
    int               rise;
  } exp_t;

  exp_t sb[$];

  // ------------------------------------------------------ m_ready generation
  int stall_id  = 0;
  int stall_len = 0;
  bit rand_ready = 1'b0;
  int seen_id = 0;
  int hold = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) hold = 0;
    else if (stall_id != seen_id) begin
      seen_id = stall_id;
      hold    = stall_len;
    end
    if (hold > 0) begin
      m_ready = 1'b0;
      if (m_valid) hold--;
    end else begin
      m_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // ----------------------------------------------------------------- monitor
  bit               prev_valid = 1'b0;
  bit               held = 1'b0;
  logic [OUT_W-1:0] held_data = '0;
  bit               post_hs = 1'b0;
  int               exp_stall = 0;
  int               exp_frame = 0;
  int               seen_err = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_valid = 1'b0;
      held       = 1'b0;
      post_hs    = 1'b0;
      exp_stall  = 0;
      exp_frame  = 0;
      seen_err   = 0;
    end else begin
      if (post_hs) begin
        check("s_ready_after_hs", 64'(s_ready), 64'(1));
        check("m_valid_after_hs", 64'(m_valid), 64'(0));
      end
      post_hs = 1'b0;
      if (held) begin
        check("hold_valid", 64'(m_valid), 64'(1));
        check("hold_data", 64'(m_data), 64'(held_data));
      end
      held = 1'b0;
      if (m_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_m_valid", 64'(m_valid), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("m_data", 64'(m_data), 64'(e.data));
          check("latency_cycle", 64'(cyc), 64'(e.rise));
        end
      end
      if (m_valid) check("s_ready_low_in_out", 64'(s_ready), 64'(0));
      if (err_len) seen_err++;
      if (m_valid && m_ready) begin
        post_hs = 1'b1;
        exp_frame = (exp_frame + 1) % 65536;
      end else if (m_valid) begin
        held      = 1'b1;
        held_data = m_data;
        if (exp_stall != 65535) exp_stall++;
      end
      prev_valid = m_valid;
    end
  end

  // ------------------------------------------------------ driver + ref model
  logic [WIDTH-1:0] model_x [IN];
  int               model_cnt = 0;
  int               exp_err_total = 0;

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(logic [WIDTH-1:0] d, logic last, int bubble_pct);
    int               t;
    bit               err;
    bit               done;
    logic [OUT_W-1:0] sum;
    int               bad;
    t = 0; err = 1'b0; done = 1'b0; sum = '0; bad = 0;
    while (bubble_pct > 0 && int'($urandom_range(99)) < bubble_pct) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        check("s_ready_timeout", 64'(s_ready), 64'(1));
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    model_x[model_cnt] = d;
    model_cnt++;
    if (model_cnt == IN) begin
      done = 1'b1;
      err  = !last;
      model_cnt = 0;
    end else if (last) begin
      err = 1'b1;
      model_cnt = 0;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("err_len", 64'(err_len), 64'(err));
    if (err) exp_err_total++;
    if (done) begin
      for (int i = 0; i < IN; i++) begin
        sum = sum + OUT_W'(model_x[i]);
        if (x_out[i] !== model_x[i]) bad++;
      end
      sb.push_back('{data: sum, rise: cyc + SETTLE_CYC});
      check("x_out_mismatch_count", 64'(bad), 64'(0));
    end
  endtask

  // kind: 0 = constant val, 1 = random. last_at < 0 means s_last never set.
  task automatic send_frame(int n, int kind, logic [WIDTH-1:0] val, int last_at,
                            int bubble_pct);
    for (int i = 0; i < n; i++) begin
      send_beat(kind == 0 ? val : WIDTH'($urandom_range(2**WIDTH - 1)),
                i == last_at, bubble_pct);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || m_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(t < 2000), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  // Asserts rst_n asynchronously between edges; called at a negedge.
  task automatic do_reset();
    int nz;
    nz = 0;
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < IN; i++) if (x_out[i] !== '0) nz++;
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_err_len", 64'(err_len), 64'(0));
    check("rst_x_out_nonzero", 64'(nz), 64'(0));
`ifdef FC_PERF_CNT_EN
    check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    s_valid = 1'b0;
    s_last  = 1'b0;
    for (int i = 0; i < IN; i++) model_x[i] = '0;
    model_cnt     = 0;
    exp_err_total = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("s_ready_before_first_clk", 64'(s_ready), 64'(0));
    @(negedge clk);
    check("s_ready_after_release", 64'(s_ready), 64'(1));
  endtask

  // -------------------------------------------------------------- sequence
  initial begin
    int t;
    for (int i = 0; i < IN; i++) model_x[i] = '0;
    @(negedge clk);
    do_reset();

    // Basic frame of ones: result 128, m_ready held high.
    send_frame(IN, 0, 8'd1, IN - 1, 0);
    drain();

    // Same frame with m_ready held low for 5 cycles of OUT.
    stall_len = 5;
    stall_id++;
    send_frame(IN, 0, 8'd1, IN - 1, 0);
    drain();
`ifdef FC_PERF_CNT_EN
    check("stall_cnt_after_stall", 64'(stall_cnt), 64'(exp_stall));
    check("frame_cnt_after_stall", 64'(frame_cnt), 64'(exp_frame));
`endif

    // Short frame (s_last on beat 10), then a full frame of twos.
    send_frame(11, 0, 8'd3, 10, 0);
    send_frame(IN, 0, 8'd2, IN - 1, 0);
    drain();

    // Full-length frame with s_last never asserted.
    send_frame(IN, 0, 8'd5, -1, 0);
    drain();

    // Random data, 50% input bubbles, random m_ready.
    rand_ready = 1'b1;
    repeat (3) send_frame(IN, 1, '0, IN - 1, 50);
    drain();
    rand_ready = 1'b0;

    // Reset in the middle of FILL, then a clean random frame.
    send_frame(60, 1, '0, -1, 0);
    do_reset();
    send_frame(IN, 1, '0, IN - 1, 0);
    drain();

    // Reset while a result is waiting in OUT, then a clean random frame.
    stall_len = 1000;
    stall_id++;
    send_frame(IN, 1, '0, IN - 1, 0);
    t = 0;
    while (!m_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reach_out_state", 64'(m_valid), 64'(1));
    repeat (3) @(negedge clk);
    do_reset();
    send_frame(IN, 1, '0, IN - 1, 0);
    drain();

    check("err_len_pulse_count", 64'(seen_err), 64'(exp_err_total));
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
`ifdef FC_PERF_CNT_EN
    check("frame_cnt_final", 64'(frame_cnt), 64'(exp_frame));
    check("stall_cnt_final", 64'(stall_cnt), 64'(exp_stall));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
